// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path: receiver state encoding,
// the default bit period for a 50 MHz clock at 9600 baud, and a short bit
// period used when simulating so that frames take a few hundred cycles.
package uart_pkg;

    // Receiver states. BREAK is entered after a bad stop bit and is left
    // only once the line has gone back high.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    // 50 MHz / 9600 baud.
    localparam int DEFAULT_BIT_TICKS = 5208;
    localparam int DEFAULT_CNT_W     = 13;

    // Short bit period for simulation.
    localparam int SIM_BIT_TICKS = 16;

endpackage : uart_pkg

// File: rtl/sync2.sv
// sync2
// Two-flop synchronizer for an asynchronous pin input. Both flops reset to
// 1 so that an idle-high line reads idle straight out of reset. Shared by
// other pin inputs besides the UART receiver.
//
// Ports:
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset (flops go to 1)
//   i_d     - asynchronous input
//   o_q     - synchronised output, two clk cycles behind i_d
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync2

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 UART receiver. Synchronises the raw RX pin, finds the start bit,
// samples each data bit in the middle of its bit period and checks the
// stop bit. A good frame updates rx_data and pulses rx_done for one cycle
// (rx_done drives the load input of the receive holding register, rx_data
// its data input). A low stop bit pulses framing_err instead and the
// receiver then waits for the line to return high before looking for the
// next start bit, so a held-low line never produces a stream of frames.
//
// Ports:
//   clk         - system clock
//   reset       - asynchronous active-low reset
//   rx          - raw serial line, idles high, asynchronous to clk
//   rx_data     - last correctly framed byte
//   rx_done     - one-cycle strobe when rx_data has just been updated
//   framing_err - one-cycle strobe when the stop bit was sampled low
//   busy        - high while a frame is in progress
//
// BIT_TICKS must be even and at least 4; 2**CNT_W must exceed BIT_TICKS.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_TICKS = DEFAULT_BIT_TICKS,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       framing_err,
    output logic       busy
);

    // The start bit is confirmed half a bit in; from then on every sample
    // is a full bit period later, which lands each one mid-bit.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_TICKS / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_TICKS - 1);

    logic              w_rxs;

    uart_state_t       r_state;
    logic [CNT_W-1:0]  r_tickCnt;
    logic [2:0]        r_bitIdx;
    logic [7:0]        r_shift;
    logic [7:0]        r_data;
    logic              r_done;
    logic              r_err;

    uart_state_t       w_stateNext;
    logic [CNT_W-1:0]  w_tickNext;
    logic [2:0]        w_bitIdxNext;
    logic [7:0]        w_shiftNext;
    logic [7:0]        w_dataNext;
    logic              w_doneNext;
    logic              w_errNext;

    sync2 u_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (rx),
        .o_q     (w_rxs)
    );

    // State and datapath registers. Strobes are registered so that they are
    // glitch-free and line up with the rx_data update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_tickCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_tickCnt <= w_tickNext;
            r_bitIdx  <= w_bitIdxNext;
            r_shift   <= w_shiftNext;
            r_data    <= w_dataNext;
            r_done    <= w_doneNext;
            r_err     <= w_errNext;
        end
    end

    // Next-state and datapath logic. Strobes default low so each one lasts
    // exactly one cycle; rx_data only moves together with rx_done.
    always_comb begin
        w_stateNext  = r_state;
        w_tickNext   = r_tickCnt;
        w_bitIdxNext = r_bitIdx;
        w_shiftNext  = r_shift;
        w_dataNext   = r_data;
        w_doneNext   = 1'b0;
        w_errNext    = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_tickNext = '0;
                if (!w_rxs) begin
                    w_stateNext = START;
                end
            end

            START: begin
                if (r_tickCnt == HALF_LAST) begin
                    w_tickNext = '0;
                    // A line that is already high again was only a glitch.
                    if (!w_rxs) begin
                        w_stateNext  = DATA;
                        w_bitIdxNext = '0;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end else begin
                    w_tickNext = r_tickCnt + 1'b1;
                end
            end

            DATA: begin
                if (r_tickCnt == FULL_LAST) begin
                    w_tickNext   = '0;
                    // LSB arrives first, so after eight right shifts it
                    // ends up in bit 0.
                    w_shiftNext  = {w_rxs, r_shift[7:1]};
                    w_bitIdxNext = r_bitIdx + 1'b1;
                    if (r_bitIdx == 3'd7) begin
                        w_stateNext = STOP;
                    end
                end else begin
                    w_tickNext = r_tickCnt + 1'b1;
                end
            end

            STOP: begin
                if (r_tickCnt == FULL_LAST) begin
                    w_tickNext = '0;
                    if (w_rxs) begin
                        w_dataNext  = r_shift;
                        w_doneNext  = 1'b1;
                        w_stateNext = IDLE;
                    end else begin
                        w_errNext   = 1'b1;
                        w_stateNext = BREAK;
                    end
                end else begin
                    w_tickNext = r_tickCnt + 1'b1;
                end
            end

            BREAK: begin
                w_tickNext = '0;
                if (w_rxs) begin
                    w_stateNext = IDLE;
                end
            end

            default: begin
                w_stateNext = IDLE;
                w_tickNext  = '0;
            end
        endcase
    end

    assign rx_data     = r_data;
    assign rx_done     = r_done;
    assign framing_err = r_err;
    assign busy        = (r_state != IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Self-checking bench for uart_rx with a 16-cycle bit period. Frames are
// driven as plain bit sequences; the expected byte, strobe counts and the
// rx_done latency window come from the frame contents and the serial
// timing, not from the receiver's internals.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BT      = SIM_BIT_TICKS;
    localparam int LAT_MIN = 2 + BT / 2 + 9 * BT;
    localparam int LAT_MAX = LAT_MIN + 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       framing_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int         cyc         = 0;
    int         doneCount   = 0;
    int         errCount    = 0;
    int         bothCount   = 0;
    int         strayChange = 0;
    int         lastDoneCyc = 0;
    int         lastErrCyc  = 0;
    logic [7:0] lastDoneData = 8'h00;
    logic [7:0] prevData     = 8'h00;

    uart_rx #(
        .BIT_TICKS (BT),
        .CNT_W     (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .framing_err (framing_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Observer: counts strobes just after each rising edge and records when
    // they happened and what rx_data held at the time.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rx_done) begin
            doneCount++;
            lastDoneCyc  = cyc;
            lastDoneData = rx_data;
        end
        if (framing_err) begin
            errCount++;
            lastErrCyc = cyc;
        end
        if (rx_done && framing_err) bothCount++;
        if (reset && !rx_done && rx_data !== prevData) strayChange++;
        prevData = rx_data;
    end

    // Hard stop in case something upstream never returns.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at a falling clock edge; returns the cycle
    // count at which the line fell.
    task automatic sendFrame(input logic [7:0] d, input logic stopBit, output int fallCyc);
        fallCyc = cyc;
        rx = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BT) @(negedge clk);
        end
        rx = stopBit;
        repeat (BT) @(negedge clk);
    endtask

    task automatic test_reset();
        int fc;
        int bd;
        int be;
        int busySeen;
        logic [7:0] d;
        @(negedge clk);
        checks++;
        if ({rx_data, rx_done, framing_err, busy} !== 11'b0) begin
            errors++;
            $display("[TB] FAIL reset_initial: got %h expected 000", {rx_data, rx_done, framing_err, busy});
        end
        reset = 1'b1;
        idle(5);
        d = 8'($urandom_range(1, 255));
        sendFrame(d, 1'b1, fc);
        checks++;
        if (rx_data !== d) begin
            errors++;
            $display("[TB] FAIL reset_preframe: got %h expected %h", rx_data, d);
        end
        rx = 1'b0;
        repeat (BT) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_busy_before: got %b expected 1", busy);
        end
        #2;
        rx    = 1'b1;
        reset = 1'b0;
        #1;
        checks++;
        if ({rx_data, rx_done, framing_err, busy} !== 11'b0) begin
            errors++;
            $display("[TB] FAIL reset_async_clear: got %h expected 000", {rx_data, rx_done, framing_err, busy});
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bd = doneCount;
        be = errCount;
        busySeen = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy) busySeen++;
        end
        checks++;
        if (doneCount !== bd || errCount !== be) begin
            errors++;
            $display("[TB] FAIL reset_idle_strobes: got done %0d err %0d expected %0d %0d", doneCount, errCount, bd, be);
        end
        checks++;
        if (busySeen !== 0) begin
            errors++;
            $display("[TB] FAIL reset_idle_busy: got %0d busy cycles expected 0", busySeen);
        end
    endtask

    task automatic test_single_frame();
        int fc;
        int bd;
        int be;
        int lat;
        bd = doneCount;
        be = errCount;
        sendFrame(8'hA5, 1'b1, fc);
        lat = lastDoneCyc - fc;
        checks++;
        if (doneCount !== bd + 1) begin
            errors++;
            $display("[TB] FAIL single_count: got %0d expected %0d", doneCount - bd, 1);
        end
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
            errors++;
            $display("[TB] FAIL single_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
        end
        checks++;
        if (lastDoneData !== 8'hA5 || rx_data !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL single_data: got %h/%h expected a5", lastDoneData, rx_data);
        end
        checks++;
        if (errCount !== be) begin
            errors++;
            $display("[TB] FAIL single_ferr: got %0d expected 0", errCount - be);
        end
        idle(BT);
    endtask

    task automatic test_back_to_back();
        int fc0;
        int fc1;
        int bd;
        int firstCyc;
        logic [7:0] firstData;
        bd = doneCount;
        sendFrame(8'h00, 1'b1, fc0);
        firstCyc  = lastDoneCyc;
        firstData = lastDoneData;
        sendFrame(8'hFF, 1'b1, fc1);
        checks++;
        if (doneCount !== bd + 2) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d expected 2", doneCount - bd);
        end
        checks++;
        if (firstData !== 8'h00 || lastDoneData !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL b2b_data: got %h,%h expected 00,ff", firstData, lastDoneData);
        end
        checks++;
        if (lastDoneCyc - firstCyc !== 10 * BT) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: got %0d expected %0d", lastDoneCyc - firstCyc, 10 * BT);
        end
        idle(BT);
    endtask

    task automatic test_glitch();
        int fc;
        int bd;
        int be;
        bd = doneCount;
        be = errCount;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_busy: got %b expected 0", busy);
        end
        checks++;
        if (doneCount !== bd || errCount !== be) begin
            errors++;
            $display("[TB] FAIL glitch_strobes: got done %0d err %0d expected 0 0", doneCount - bd, errCount - be);
        end
        idle(4);
        sendFrame(8'h3C, 1'b1, fc);
        checks++;
        if (doneCount !== bd + 1 || lastDoneData !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL glitch_next_frame: got %0d pulses data %h expected 1 3c", doneCount - bd, lastDoneData);
        end
        idle(BT);
    endtask

    task automatic test_framing_error();
        int fc;
        int bd;
        int be;
        int lat;
        logic [7:0] prior;
        prior = 8'($urandom_range(0, 255));
        if (prior == 8'h3C) prior = 8'hC3;
        sendFrame(prior, 1'b1, fc);
        idle(3);
        bd = doneCount;
        be = errCount;
        sendFrame(8'h3C, 1'b0, fc);
        repeat (100) @(negedge clk);
        lat = lastErrCyc - fc;
        checks++;
        if (errCount !== be + 1) begin
            errors++;
            $display("[TB] FAIL ferr_count: got %0d expected 1", errCount - be);
        end
        checks++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
            errors++;
            $display("[TB] FAIL ferr_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
        end
        checks++;
        if (doneCount !== bd || rx_data !== prior) begin
            errors++;
            $display("[TB] FAIL ferr_hold: got %0d pulses data %h expected 0 %h", doneCount - bd, rx_data, prior);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ferr_break_busy: got %b expected 1", busy);
        end
        idle(6);
        checks++;
        if (busy !== 1'b0 || errCount !== be + 1) begin
            errors++;
            $display("[TB] FAIL ferr_release: got busy %b err %0d expected 0 1", busy, errCount - be);
        end
        sendFrame(8'h81, 1'b1, fc);
        checks++;
        if (doneCount !== bd + 1 || lastDoneData !== 8'h81) begin
            errors++;
            $display("[TB] FAIL ferr_next_frame: got %0d pulses data %h expected 1 81", doneCount - bd, lastDoneData);
        end
        idle(BT);
    endtask

    task automatic test_reset_mid_frame();
        int fc;
        int bd;
        int be;
        logic [7:0] d;
        d  = 8'hC3;
        bd = doneCount;
        be = errCount;
        rx = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (BT) @(negedge clk);
        end
        rx = d[4];
        repeat (BT / 2) @(negedge clk);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        idle(20);
        checks++;
        if (doneCount !== bd || errCount !== be || rx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL abort_no_strobe: got done %0d err %0d data %h expected 0 0 00", doneCount - bd, errCount - be, rx_data);
        end
        sendFrame(8'h5A, 1'b1, fc);
        checks++;
        if (doneCount !== bd + 1 || rx_data !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL abort_next_frame: got %0d pulses data %h expected 1 5a", doneCount - bd, rx_data);
        end
        idle(BT);
    endtask

    // Random bytes with random gaps (including none) and occasional bad stop
    // bits. The model is simply "rx_data is the last byte sent with a good
    // stop bit", seeded with the byte the previous scenario ended on.
    task automatic test_random_frames();
        int fc;
        int bd;
        int be;
        int lat;
        int gap;
        logic [7:0] d;
        logic       bad;
        logic [7:0] expData;
        expData = 8'h5A;
        for (int n = 0; n < 24; n++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            gap = bad ? $urandom_range(3, 20) : $urandom_range(0, 20);
            bd  = doneCount;
            be  = errCount;
            sendFrame(d, !bad, fc);
            if (!bad) expData = d;
            lat = bad ? (lastErrCyc - fc) : (lastDoneCyc - fc);
            checks++;
            if (doneCount !== bd + (bad ? 0 : 1) || errCount !== be + (bad ? 1 : 0)) begin
                errors++;
                $display("[TB] FAIL rand_strobes[%0d]: got done %0d err %0d expected bad=%b", n, doneCount - bd, errCount - be, bad);
            end
            checks++;
            if (rx_data !== expData) begin
                errors++;
                $display("[TB] FAIL rand_data[%0d]: got %h expected %h", n, rx_data, expData);
            end
            checks++;
            if (lat < LAT_MIN || lat > LAT_MAX) begin
                errors++;
                $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d..%0d", n, lat, LAT_MIN, LAT_MAX);
            end
            idle(gap);
        end
        idle(BT);
    endtask

    task automatic test_invariants();
        checks++;
        if (bothCount !== 0) begin
            errors++;
            $display("[TB] FAIL both_strobes: got %0d cycles expected 0", bothCount);
        end
        checks++;
        if (strayChange !== 0) begin
            errors++;
            $display("[TB] FAIL data_without_done: got %0d changes expected 0", strayChange);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_random_frames();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx
